// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Issue stage in front of a combinational RV32I ALU. Decoded instruction
// fields (R-type, I-type, LUI, AUIPC) are accepted through a valid/ready
// handshake. The operands are selected and ALU_FUN is encoded into the S1
// register, which drives the ALU directly. The ALU result is captured in the
// S2 register and returned downstream through a second valid/ready handshake.
//
// Optional build macro: ALU_ISSUE_SKID_EN
//   undefined : no skid buffer, IN_READY is combinational
//   defined   : one-entry skid buffer ahead of S1, IN_READY is registered
//
// Ports:
//   CLK          clock, rising edge
//   RST_N        synchronous active-low reset
//   IN_VALID     instruction fields valid
//   IN_READY     stage accepts an instruction this cycle
//   OPCODE       instruction opcode [6:0]
//   FUNCT3       instruction funct3
//   FUNCT7_5     instruction bit 30
//   RS1_DATA     rs1 value
//   RS2_DATA     rs2 value
//   IMM          sign-extended immediate (U-immediate already shifted)
//   PC           instruction address
//   OP_A, OP_B   operands to the ALU (registered)
//   ALU_FUN      ALU function code (registered)
//   RESULT       ALU result, combinational from OP_A/OP_B/ALU_FUN
//   ZERO         ALU zero flag
//   OUT_VALID    result valid
//   OUT_READY    downstream accepts the result
//   OUT_RESULT   registered result (0 for unsupported instructions)
//   OUT_ZERO     registered zero flag (1 for unsupported instructions)
//   OUT_ILLEGAL  instruction was unsupported
// -----------------------------------------------------------------------------
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [6:0]      OPCODE,
    input  logic [2:0]      FUNCT3,
    input  logic            FUNCT7_5,
    input  logic [XLEN-1:0] RS1_DATA,
    input  logic [XLEN-1:0] RS2_DATA,
    input  logic [XLEN-1:0] IMM,
    input  logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] OP_A,
    output logic [XLEN-1:0] OP_B,
    output logic [3:0]      ALU_FUN,
    input  logic [XLEN-1:0] RESULT,
    input  logic            ZERO,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] OUT_RESULT,
    output logic            OUT_ZERO,
    output logic            OUT_ILLEGAL
);

    // Opcodes of the supported instruction classes
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // ALU function codes that the decoder produces explicitly; the others are
    // formed directly from {FUNCT7_5, FUNCT3}
    localparam logic [3:0] FUN_ADD = 4'b0000;
    localparam logic [3:0] FUN_SLL = 4'b0001;
    localparam logic [3:0] FUN_LUI = 4'b1001;

    // ------------------------------------------------------------------
    // Decode of the presented instruction
    // ------------------------------------------------------------------
    logic [XLEN-1:0] dec_op_a_s;
    logic [XLEN-1:0] dec_op_b_s;
    logic [3:0]      dec_fun_s;
    logic            dec_ill_s;

    // Operand selection, function encoding and legality of the input fields
    always_comb begin
        dec_op_a_s = {XLEN{1'b0}};
        dec_op_b_s = {XLEN{1'b0}};
        dec_fun_s  = FUN_ADD;
        dec_ill_s  = 1'b0;
        case (OPCODE)
            OPC_OP: begin
                dec_op_a_s = RS1_DATA;
                dec_op_b_s = RS2_DATA;
                dec_fun_s  = {FUNCT7_5, FUNCT3};
                // Only SUB and SRA use bit 30 in R-type
                if (FUNCT7_5 && (FUNCT3 != 3'b000) && (FUNCT3 != 3'b101)) begin
                    dec_ill_s = 1'b1;
                end else begin
                    dec_ill_s = 1'b0;
                end
            end
            OPC_OPIMM: begin
                dec_op_a_s = RS1_DATA;
                dec_op_b_s = IMM;
                case (FUNCT3)
                    3'b101: begin
                        dec_fun_s = {FUNCT7_5, 3'b101};
                    end
                    3'b001: begin
                        dec_fun_s = FUN_SLL;
                        dec_ill_s = FUNCT7_5;
                    end
                    default: begin
                        // Bit 30 is part of the immediate here, not a selector
                        dec_fun_s = {1'b0, FUNCT3};
                    end
                endcase
            end
            OPC_LUI: begin
                dec_op_a_s = IMM;
                dec_op_b_s = {XLEN{1'b0}};
                dec_fun_s  = FUN_LUI;
            end
            OPC_AUIPC: begin
                dec_op_a_s = PC;
                dec_op_b_s = IMM;
                dec_fun_s  = FUN_ADD;
            end
            default: begin
                dec_ill_s = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic            s1_valid_q;
    logic [XLEN-1:0] s1_op_a_q;
    logic [XLEN-1:0] s1_op_b_q;
    logic [3:0]      s1_fun_q;
    logic            s1_ill_q;

    logic            s2_valid_q;
    logic [XLEN-1:0] s2_result_q;
    logic            s2_zero_q;
    logic            s2_ill_q;

    logic            s1_adv_s;   // S1 entry moves into S2 on this edge
    logic            s1_free_s;  // S1 can take a new entry on this edge
    logic            s1_load_s;  // S1 loads src_* on this edge
    logic            in_fire_s;  // input handshake completes on this edge

    // Entry offered to S1 (the decoder output, or the skid entry when present)
    logic [XLEN-1:0] src_op_a_s;
    logic [XLEN-1:0] src_op_b_s;
    logic [3:0]      src_fun_s;
    logic            src_ill_s;

    assign s1_adv_s  = s1_valid_q && (!s2_valid_q || OUT_READY);
    assign s1_free_s = !s1_valid_q || s1_adv_s;

`ifdef ALU_ISSUE_SKID_EN
    // ------------------------------------------------------------------
    // One-entry skid buffer: catches an input accepted while S1 stalls so
    // that IN_READY can come straight from a flop.
    // ------------------------------------------------------------------
    logic            skid_full_q;
    logic            skid_full_d;
    logic            in_ready_q;
    logic [XLEN-1:0] skid_op_a_q;
    logic [XLEN-1:0] skid_op_b_q;
    logic [3:0]      skid_fun_q;
    logic            skid_ill_q;
    logic            skid_load_s;

    assign IN_READY    = in_ready_q;
    assign in_fire_s   = IN_VALID && in_ready_q;
    // The skid entry is older than anything arriving now, so it goes first
    assign s1_load_s   = s1_free_s && (skid_full_q || in_fire_s);
    assign skid_load_s = in_fire_s && (skid_full_q || !s1_free_s);

    // Entry presented to S1: skid contents take priority over new input
    always_comb begin
        if (skid_full_q) begin
            src_op_a_s = skid_op_a_q;
            src_op_b_s = skid_op_b_q;
            src_fun_s  = skid_fun_q;
            src_ill_s  = skid_ill_q;
        end else begin
            src_op_a_s = dec_op_a_s;
            src_op_b_s = dec_op_b_s;
            src_fun_s  = dec_fun_s;
            src_ill_s  = dec_ill_s;
        end
    end

    // Skid occupancy after this edge
    always_comb begin
        if (in_fire_s) begin
            skid_full_d = skid_full_q || !s1_free_s;
        end else begin
            skid_full_d = skid_full_q && !s1_free_s;
        end
    end

    // Skid buffer storage and registered ready
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            skid_full_q <= 1'b0;
            in_ready_q  <= 1'b0;
            skid_op_a_q <= {XLEN{1'b0}};
            skid_op_b_q <= {XLEN{1'b0}};
            skid_fun_q  <= 4'b0000;
            skid_ill_q  <= 1'b0;
        end else begin
            skid_full_q <= skid_full_d;
            in_ready_q  <= !skid_full_d;
            if (skid_load_s) begin
                skid_op_a_q <= dec_op_a_s;
                skid_op_b_q <= dec_op_b_s;
                skid_fun_q  <= dec_fun_s;
                skid_ill_q  <= dec_ill_s;
            end else begin
                skid_op_a_q <= skid_op_a_q;
                skid_op_b_q <= skid_op_b_q;
                skid_fun_q  <= skid_fun_q;
                skid_ill_q  <= skid_ill_q;
            end
        end
    end
`else
    // ------------------------------------------------------------------
    // No skid buffer: ready is the combinational "S1 will be free" term
    // ------------------------------------------------------------------
    assign IN_READY   = RST_N && s1_free_s;
    assign in_fire_s  = IN_VALID && IN_READY;
    assign s1_load_s  = in_fire_s;
    assign src_op_a_s = dec_op_a_s;
    assign src_op_b_s = dec_op_b_s;
    assign src_fun_s  = dec_fun_s;
    assign src_ill_s  = dec_ill_s;
`endif

    // S1 issue register; it drives the ALU and keeps its last operands when empty
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_valid_q <= 1'b0;
            s1_op_a_q  <= {XLEN{1'b0}};
            s1_op_b_q  <= {XLEN{1'b0}};
            s1_fun_q   <= 4'b0000;
            s1_ill_q   <= 1'b0;
        end else if (s1_load_s) begin
            s1_valid_q <= 1'b1;
            s1_op_a_q  <= src_op_a_s;
            s1_op_b_q  <= src_op_b_s;
            s1_fun_q   <= src_fun_s;
            s1_ill_q   <= src_ill_s;
        end else if (s1_adv_s) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_q;
        end
    end

    // S2 result register; an unsupported instruction reports 0 with ZERO set
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= {XLEN{1'b0}};
            s2_zero_q   <= 1'b0;
            s2_ill_q    <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_q  <= 1'b1;
            s2_ill_q    <= s1_ill_q;
            if (s1_ill_q) begin
                s2_result_q <= {XLEN{1'b0}};
                s2_zero_q   <= 1'b1;
            end else begin
                s2_result_q <= RESULT;
                s2_zero_q   <= ZERO;
            end
        end else if (OUT_READY) begin
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_q;
        end
    end

    assign OP_A        = s1_op_a_q;
    assign OP_B        = s1_op_b_q;
    assign ALU_FUN     = s1_fun_q;
    assign OUT_VALID   = s2_valid_q;
    assign OUT_RESULT  = s2_result_q;
    assign OUT_ZERO    = s2_zero_q;
    assign OUT_ILLEGAL = s2_ill_q;

endmodule
